// File: rtl/embcpu4k_nios2_qsys_0_jtag_debug_host.sv
// Host (initiator) end of a 2-bit-IR virtual JTAG debug link: runs UIR[,CDR,SDR*N,UDR],RTI per command.
// Latency accept to rsp_valid = 1 + periods*2*TCK_HALF clk; cmd_ready low while a scan is in flight.
module embcpu4k_nios2_qsys_0_jtag_debug_host #(
    parameter int DR_WIDTH = 38,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic                cmd_ir_only,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic [1:0]          vji_ir_in,
    input  logic                vji_tdo,
    input  logic [1:0]          vji_ir_out
);

    localparam int CW = 5;
    localparam int BW = $clog2(DR_WIDTH + 1);
    localparam logic [CW-1:0] HALF  = CW'(TCK_HALF);
    localparam logic [CW-1:0] LAST  = CW'(2 * TCK_HALF - 1);
    localparam logic [BW-1:0] BLAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI} state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic                ready_q, ready_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic                ir_only_q, ir_only_d;
    logic [1:0]          ir_q, ir_d;
    logic                smp_q, smp_d;
    logic [1:0]          ir_in_q, ir_in_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [1:0]          rsp_ir_q, rsp_ir_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic [4:0]          flags_q, flags_d;
    logic                tdo_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            ready_q     <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ir_only_q   <= 1'b0;
            ir_q        <= '0;
            smp_q       <= 1'b0;
            ir_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dr_q    <= '0;
            rsp_ir_q    <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ir_only_q   <= ir_only_d;
            ir_q        <= ir_d;
            smp_q       <= smp_d;
            ir_in_q     <= ir_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dr_q    <= rsp_dr_d;
            rsp_ir_q    <= rsp_ir_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            flags_q     <= flags_d;
        end
    end

    // With TCK_HALF=1 the tck-high cycle is also the period's last, so take tdo live.
    assign tdo_bit = (cnt_q == HALF) ? vji_tdo : smp_q;

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        ready_d     = ready_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        ir_only_d   = ir_only_q;
        ir_d        = ir_q;
        smp_d       = smp_q;
        ir_in_d     = ir_in_q;
        rsp_valid_d = 1'b0;
        rsp_dr_d    = rsp_dr_q;
        rsp_ir_d    = rsp_ir_q;
        if (state_q == S_IDLE) begin
            if (start_q) begin
                state_d = S_UIR;
                cnt_d   = '0;
                start_d = 1'b0;
                ir_in_d = ir_q;
            end else if (cmd_valid && ready_q) begin
                ready_d   = 1'b0;
                start_d   = 1'b1;
                ir_d      = cmd_ir;
                ir_only_d = cmd_ir_only;
                shift_d   = cmd_dr;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == HALF) begin
                smp_d = vji_tdo;
                if (state_q == S_UIR) rsp_ir_d = vji_ir_out;
            end
            if (cnt_q == LAST) begin
                cnt_d = '0;
                case (state_q)
                    S_UIR: state_d = ir_only_q ? S_RTI : S_CDR;
                    S_CDR: begin
                        state_d = S_SDR;
                        bit_d   = '0;
                    end
                    S_SDR: begin
                        shift_d = {tdo_bit, shift_q[DR_WIDTH-1:1]};
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BLAST) state_d = S_UDR;
                    end
                    S_UDR: state_d = S_RTI;
                    S_RTI: begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                        ready_d     = 1'b1;
                        if (!ir_only_q) rsp_dr_d = shift_q;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
        // Pin outputs are registered from next-state so they change together with state_q.
        tck_d   = (state_d != S_IDLE) && (cnt_d >= HALF);
        tdi_d   = (state_d == S_SDR) ? shift_d[0] : 1'b0;
        flags_d = {state_d == S_RTI, state_d == S_UDR, state_d == S_SDR,
                   state_d == S_CDR, state_d == S_UIR};
    end

    assign cmd_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dr     = rsp_dr_q;
    assign rsp_ir_out = rsp_ir_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_uir    = flags_q[0];
    assign vji_cdr    = flags_q[1];
    assign vji_sdr    = flags_q[2];
    assign vji_udr    = flags_q[3];
    assign vji_rti    = flags_q[4];
    assign vji_ir_in  = ir_in_q;

endmodule

// File: doc/embcpu4k_nios2_qsys_0_jtag_debug_host.md
EMBCPU4K_NIOS2_QSYS_0_JTAG_DEBUG_HOST -- requirements
Module: embcpu4k_nios2_qsys_0_jtag_debug_host

Interface
REQ-001 Parameter DR_WIDTH, default 38: data-register scan length in TCK periods.
REQ-002 Parameter TCK_HALF, default 2: clk cycles per TCK half-period, legal range 1..15.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  high only in IDLE; accept = cmd_valid & cmd_ready on a clk edge.
REQ-007 cmd_ir  input  2  virtual IR value to load.
REQ-008 cmd_ir_only  input  1  1 = IR update only, no DR scan.
REQ-009 cmd_dr  input  DR_WIDTH  DR payload, shifted LSB first.
REQ-010 rsp_valid  output  1  one-clk pulse, scan complete.
REQ-011 rsp_dr  output  DR_WIDTH  captured tdo bits, bit 0 = first bit shifted out; held until next rsp_valid.
REQ-012 rsp_ir_out  output  2  vji_ir_out sampled during UIR.
REQ-013 vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  output  1 each  virtual JTAG drive toward the debug module.
REQ-014 vji_ir_in  output  2  IR value driven to the debug module.
REQ-015 vji_tdo  input  1; vji_ir_out  input  2: returns from the debug module.

Function
REQ-016 Host (initiator) end of the 2-bit-IR virtual JTAG debug interface; all outputs registered.
REQ-017 FSM states: IDLE, UIR, CDR, SDR, UDR, RTI; exactly one of vji_uir/cdr/sdr/udr/rti high outside IDLE, all low in IDLE.
REQ-018 TCK period = 2*TCK_HALF clk cycles: first TCK_HALF cycles vji_tck=0, next TCK_HALF cycles vji_tck=1; vji_tck=0 throughout IDLE.
REQ-019 State changes and vji_tdi changes occur only at TCK period start (tck low phase start).
REQ-020 Accept in IDLE: latch cmd_*, cmd_ready low next cycle, UIR begins next cycle.
REQ-021 UIR: 1 period; vji_ir_in <= latched cmd_ir at UIR start and held until next UIR; rsp_ir_out <= vji_ir_out at the tck rising cycle.
REQ-022 Sequence: cmd_ir_only=0 -> UIR, CDR(1), SDR(DR_WIDTH), UDR(1), RTI(1); cmd_ir_only=1 -> UIR, RTI.
REQ-023 SDR: vji_tdi = shift_reg[0]; vji_tdo sampled on the clk cycle vji_tck goes 1; at period end shift_reg <= {sampled_tdo, shift_reg[DR_WIDTH-1:1]}.
REQ-024 Bit counter counts DR_WIDTH periods exactly in SDR; no wrap beyond DR_WIDTH.
REQ-025 After RTI period: rsp_valid pulses 1 cycle, rsp_dr <= shift_reg (ir_only: rsp_dr unchanged), state IDLE, cmd_ready high same cycle.
REQ-026 Latency accept-edge to rsp_valid = 1 + (DR_WIDTH+4)*2*TCK_HALF clk cycles (169 default); ir_only = 1 + 4*TCK_HALF (9 default).
REQ-027 cmd_valid while busy ignored; cmd_* changes while busy have no effect; back-to-back accept legal in the cycle cmd_ready re-asserts.
REQ-028 vji_tdi = 0 outside SDR.

Reset
REQ-029 reset_n low: immediately state IDLE, cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0, vji_ir_in=0, all vji_* 1-bit outputs 0, counters and shift_reg 0.
REQ-030 Reset mid-scan aborts with no rsp_valid; first accept after release behaves as from power-up.

Verification
REQ-031 cmd_ir=2'b01, cmd_dr=38'h2A_5555_5555, vji_tdo looped from vji_tdi -> rsp_valid at cycle 169, rsp_dr=38'h2A_5555_5555, 38 SDR periods counted.
REQ-032 cmd_ir_only=1, cmd_ir=2'b11, vji_ir_out=2'b10 -> UIR then RTI only, rsp_valid at cycle 9, rsp_ir_out=2'b10, vji_ir_in=2'b11 held after.
REQ-033 vji_tdo tied 1, cmd_dr=0 -> rsp_dr=38'h3F_FFFF_FFFF; vji_tdi=0 every SDR period.
REQ-034 cmd_valid held high with new cmd_* during scan -> second command accepted only on rsp_valid cycle, uses values present then.
REQ-035 reset_n low at cycle 60 of a DR scan -> all outputs at reset values same cycle, no rsp_valid; next command completes normally.
REQ-036 TCK_HALF=1 and TCK_HALF=3 builds -> tck high/low phases 1 and 3 cycles, latency formula REQ-026 holds.
